// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
//
// Purpose:
//   Shares the single word-access interface of the write-through cache between
//   two requesters: port 0 (instruction fetch) and port 1 (data load/store).
//   A round-robin arbiter picks a winner, a four-state sequencer issues a
//   one-cycle mem_read/mem_write, waits for the cache stall to clear and then
//   returns read data (or a plain write acknowledge) to the winning port.
//
//   Sequence: IDLE -> ISSUE -> WAIT -> RESP -> IDLE (each state >= 1 cycle).
//
// Optional feature (macro STALL_TIMEOUT_EN):
//   When defined, a stall counter aborts a WAIT that lasts MAX_STALL cycles
//   with stall high; the port receives ack together with err and its rdata is
//   left untouched. When undefined, no counter is built, WAIT can last forever
//   and p0_err/p1_err are tied low.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   pN_req/we/addr/wdata  requester N command, held until pN_ack
//   pN_ack                one-cycle completion pulse
//   pN_rdata              read data, held until the next ack to that port
//   pN_err                abort flag, pulses with ack (timeout build only)
//   WordAddress, DataIn   address / write data towards the cache
//   mem_read, mem_write   one-cycle commands towards the cache
//   stall, DataOut        cache busy flag and read data from the cache
//   busy                  high whenever the sequencer is not in IDLE
//   grant_id              port currently owning the cache (valid while busy)
// -----------------------------------------------------------------------------
module cache_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STALL  = 255,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  output logic [ADDR_WIDTH-1:0] WordAddress,
  output logic [DATA_WIDTH-1:0] DataIn,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  stall,
  input  logic [DATA_WIDTH-1:0] DataOut,
  output logic                  busy,
  output logic                  grant_id
);

  // The stall counter must be able to represent MAX_STALL.
  if (CNT_WIDTH < $clog2(MAX_STALL + 1)) begin : g_bad_cnt_width
    $error("CNT_WIDTH too narrow to hold MAX_STALL");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_last_grant;
  logic                  r_grant_id;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_p0_rdata;
  logic [DATA_WIDTH-1:0] r_p1_rdata;

  logic                  w_accept;
  logic                  w_grant_next;
  logic                  w_capture;
  logic                  w_resp;

`ifdef STALL_TIMEOUT_EN
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic                  r_err;
  logic                  w_timeout;

  // This WAIT edge would be the MAX_STALL-th stalled cycle: give up now.
  assign w_timeout = (r_state == S_WAIT) && stall &&
                     (r_stall_cnt >= CNT_WIDTH'(MAX_STALL - 1));
`endif

  // ---------------------------------------------------------------------------
  // Next-state / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_grant_next = r_grant_id;
    w_capture    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (p0_req && p1_req) begin
          // Tie: the port that did not win last time goes first.
          w_accept     = 1'b1;
          w_grant_next = ~r_last_grant;
        end else if (p0_req) begin
          w_accept     = 1'b1;
          w_grant_next = 1'b0;
        end else if (p1_req) begin
          w_accept     = 1'b1;
          w_grant_next = 1'b1;
        end
        if (w_accept) begin
          w_state_next = S_ISSUE;
        end
      end

      S_ISSUE: begin
        w_state_next = S_WAIT;
      end

      S_WAIT: begin
        if (!stall) begin
          w_state_next = S_RESP;
          w_capture    = ~r_we;
        end
`ifdef STALL_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_next = S_RESP;
        end
`endif
      end

      S_RESP: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;  // makes port 0 the first tie winner
      r_grant_id   <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_p0_rdata   <= '0;
      r_p1_rdata   <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_grant_id <= w_grant_next;
        r_we       <= w_grant_next ? p1_we    : p0_we;
        r_addr     <= w_grant_next ? p1_addr  : p0_addr;
        r_wdata    <= w_grant_next ? p1_wdata : p0_wdata;
      end

      if (w_capture) begin
        if (r_grant_id) begin
          r_p1_rdata <= DataOut;
        end else begin
          r_p0_rdata <= DataOut;
        end
      end

      if (r_state == S_RESP) begin
        r_last_grant <= r_grant_id;
      end
    end
  end

`ifdef STALL_TIMEOUT_EN
  // Stall counter: cleared while in ISSUE (i.e. on entry to WAIT), counts
  // stalled WAIT cycles and saturates at MAX_STALL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_stall_cnt <= '0;
      end else if ((r_state == S_WAIT) && stall &&
                   (r_stall_cnt != CNT_WIDTH'(MAX_STALL))) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      // The value left here when WAIT exits is what RESP reports.
      if (r_state == S_WAIT) begin
        r_err <= w_timeout;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign w_resp      = (r_state == S_RESP);

  assign busy        = (r_state != S_IDLE);
  assign grant_id    = r_grant_id;
  assign WordAddress = r_addr;
  assign DataIn      = r_wdata;
  assign mem_read    = (r_state == S_ISSUE) && !r_we;
  assign mem_write   = (r_state == S_ISSUE) &&  r_we;

  assign p0_ack      = w_resp && !r_grant_id;
  assign p1_ack      = w_resp &&  r_grant_id;
  assign p0_rdata    = r_p0_rdata;
  assign p1_rdata    = r_p1_rdata;

`ifdef STALL_TIMEOUT_EN
  assign p0_err      = w_resp && !r_grant_id && r_err;
  assign p1_err      = w_resp &&  r_grant_id && r_err;
`else
  assign p0_err      = 1'b0;
  assign p1_err      = 1'b0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_port_arbiter
//
// Directed bench for cache_port_arbiter. Inputs are driven and outputs sampled
// 1 time unit after each rising clock edge. Expected values are hand-derived
// from the intended sequencing (accept edge, ISSUE, WAIT..., RESP, IDLE).
// MAX_STALL is set to 8 so the timeout build aborts after 8 stalled cycles.
// -----------------------------------------------------------------------------
module tb_cache_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          stall = 1'b0;
  logic [DW-1:0] DataOut = '0;

  logic          p0_ack, p0_err, p1_ack, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] WordAddress;
  logic [DW-1:0] DataIn;
  logic          mem_read, mem_write, busy, grant_id;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] m_rdata [2];

  cache_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_STALL (8),
    .CNT_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .p0_req     (p0_req),
    .p0_we      (p0_we),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p0_ack     (p0_ack),
    .p0_rdata   (p0_rdata),
    .p0_err     (p0_err),
    .p1_req     (p1_req),
    .p1_we      (p1_we),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p1_ack     (p1_ack),
    .p1_rdata   (p1_rdata),
    .p1_err     (p1_err),
    .WordAddress(WordAddress),
    .DataIn     (DataIn),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .stall      (stall),
    .DataOut    (DataOut),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_cmd"}, {mem_read, mem_write}, 0);
    check_val({tag, "_acks"}, {p1_ack, p0_ack}, 0);
  endtask

  task automatic set_port(input int port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    if (port == 0) begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end
  endtask

  // One full transaction, starting in IDLE with the winner's req already high.
  task automatic txn(input int port, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [DW-1:0] dout,
                     input int nstall, input bit reassert);
    tick();  // ISSUE
    check_val("issue_busy", busy, 1);
    check_val("issue_grant", grant_id, 32'(port[0]));
    check_val("issue_mem_read", mem_read, 32'(!we));
    check_val("issue_mem_write", mem_write, 32'(we));
    check_val("issue_addr", WordAddress, 32'(addr));
    check_val("issue_din", DataIn, wdata);
    check_val("issue_acks", {p1_ack, p0_ack}, 0);
    tick();  // WAIT
    for (int i = 0; i <= nstall; i++) begin
      check_val("wait_cmd", {mem_read, mem_write}, 0);
      check_val("wait_addr", WordAddress, 32'(addr));
      check_val("wait_din", DataIn, wdata);
      check_val("wait_acks", {p1_ack, p0_ack}, 0);
      check_val("wait_err", {p1_err, p0_err}, 0);
      check_val("wait_busy", busy, 1);
      stall   = (i < nstall);
      DataOut = (i < nstall) ? (32'hDEAD0000 | 32'(i)) : dout;
      tick();
    end
    stall = 1'b0;
    // RESP
    if (!we) m_rdata[port] = dout;
    check_val("resp_acks", {p1_ack, p0_ack}, (port == 1) ? 2'b10 : 2'b01);
    check_val("resp_err", {p1_err, p0_err}, 0);
    check_val("resp_rdata0", p0_rdata, m_rdata[0]);
    check_val("resp_rdata1", p1_rdata, m_rdata[1]);
    check_val("resp_busy", busy, 1);
    check_val("resp_cmd", {mem_read, mem_write}, 0);
    if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
    tick();  // IDLE
    check_idle("post_resp");
    if (reassert) begin
      if (port == 0) p0_req = 1'b1; else p1_req = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  initial begin
    m_rdata[0] = '0;
    m_rdata[1] = '0;

    // Reset state
    tick();
    check_idle("reset");
    check_val("reset_grant", grant_id, 0);
    check_val("reset_addr", WordAddress, 0);
    check_val("reset_din", DataIn, 0);
    check_val("reset_rdata", {p0_rdata, p1_rdata}, 0);
    check_val("reset_err", {p1_err, p0_err}, 0);
    do_reset();

    // Read hit on port 0
    set_port(0, 1'b0, 10'd1, 32'h11);
    txn(0, 1'b0, 10'd1, 32'h11, 32'd5, 0, 1'b0);

    // Write on port 1 with 4 stalled cycles
    set_port(1, 1'b1, 10'd3, 32'd10);
    txn(1, 1'b1, 10'd3, 32'd10, 32'h0BAD, 4, 1'b0);

    // Simultaneous requests after reset: port 0 first, then port 1
    do_reset();
    set_port(0, 1'b0, 10'd1, 32'h0);
    set_port(1, 1'b0, 10'd4, 32'h0);
    txn(0, 1'b0, 10'd1, 32'h0, 32'd7, 0, 1'b0);
    txn(1, 1'b0, 10'd4, 32'h0, 32'd9, 1, 1'b0);

    // Fairness: both held for six transactions
    set_port(0, 1'b0, 10'h10, 32'h0);
    set_port(1, 1'b1, 10'h20, 32'hABC);
    for (int k = 0; k < 6; k++) begin
      txn(k % 2, (k % 2) == 1, ((k % 2) == 1) ? 10'h20 : 10'h10,
          ((k % 2) == 1) ? 32'hABC : 32'h0, 32'h100 + 32'(k), k % 3, 1'b1);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    check_idle("fair_done");

    // Reset during WAIT
    set_port(0, 1'b0, 10'd2, 32'h77);
    tick();  // ISSUE
    stall = 1'b1;
    tick();  // WAIT
    tick();  // WAIT
    check_val("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_idle("async_reset");
    check_val("async_reset_grant", grant_id, 0);
    check_val("async_reset_addr", WordAddress, 0);
    check_val("async_reset_din", DataIn, 0);
    check_val("async_reset_rdata", {p0_rdata, p1_rdata}, 0);
    check_val("async_reset_err", {p1_err, p0_err}, 0);
    p0_req = 1'b0;
    stall = 1'b0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("after_reset");
    end
    set_port(0, 1'b0, 10'd2, 32'h0);
    txn(0, 1'b0, 10'd2, 32'h0, 32'h55, 0, 1'b0);

    // Stall held high: timeout abort, or indefinite wait without the feature
    set_port(0, 1'b0, 10'd5, 32'h0);
`ifdef STALL_TIMEOUT_EN
    tick();  // ISSUE
    check_val("to_mem_read", mem_read, 1);
    stall = 1'b1;
    DataOut = 32'hBEEF;
    tick();  // WAIT
    for (int i = 0; i < 8; i++) begin
      check_val("to_wait_busy", busy, 1);
      check_val("to_wait_acks", {p1_ack, p0_ack}, 0);
      check_val("to_wait_err", {p1_err, p0_err}, 0);
      tick();
    end
    check_val("to_resp_ack", {p1_ack, p0_ack}, 2'b01);
    check_val("to_resp_err", {p1_err, p0_err}, 2'b01);
    check_val("to_resp_rdata", p0_rdata, m_rdata[0]);
    p0_req = 1'b0;
    stall = 1'b0;
    tick();
    check_idle("to_idle");
`else
    txn(0, 1'b0, 10'd5, 32'h0, 32'h66, 20, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
